// File: rtl/spi_rx_pkg.sv
// Shared frame layout and defaults for the SPI write-frame receiver.
package spi_rx_pkg;

  localparam int FRAME_W      = 16;
  localparam int RW_BIT       = 15;
  localparam int ADDR_MSB     = 14;
  localparam int ADDR_LSB     = 8;
  localparam int DATA_MSB     = 7;
  localparam int DATA_LSB     = 0;
  localparam int ADDR_W       = ADDR_MSB - ADDR_LSB + 1;
  localparam int DATA_W       = DATA_MSB - DATA_LSB + 1;
  localparam logic RW_WRITE   = 1'b1;
  localparam int NUM_REGS_DEF = 5;
  localparam int CNT_W        = 5;
  localparam int CNT_MAX      = FRAME_W + 1;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_FRAME
  } state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Write handshake from the SPI frame receiver to the register bank.
interface spi_frame_rx_if;
  import spi_rx_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin with selectable reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 write-frame receiver driving a valid/ready register write port.
// Error counter is built only when SPI_FRAME_RX_ERR_CNT_EN is defined.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = NUM_REGS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             copi,
  input  logic             cs_n,
  spi_frame_rx_if.master   wr,
  output logic [7:0]       err_cnt
);

  logic sclk_s, copi_s, cs_s;
  logic sclk_q, cs_q;
  logic sclk_rise, cs_fall, cs_rise;
  logic [FRAME_W-1:0] shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic [1:0]         settle;
  logic               settled;
  state_t             state;
  logic               is_write, addr_ok, len_ok, eval, accept;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst(rst), .d(copi), .q(copi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d(cs_n), .q(cs_s));

  always_comb begin
    sclk_rise = sclk_s & ~sclk_q;
    cs_fall   = ~cs_s & cs_q;
    cs_rise   = cs_s & ~cs_q;
    settled   = (settle == 2'(SYNC_STAGES));
    is_write  = (shift[RW_BIT] == RW_WRITE);
    addr_ok   = (int'(shift[ADDR_MSB:ADDR_LSB]) < NUM_REGS);
    len_ok    = (bit_cnt == CNT_W'(FRAME_W));
    eval      = (state == ST_FRAME) && cs_rise;
    accept    = eval && len_ok && is_write && addr_ok && !wr.wr_valid;
  end

  // ST_SETTLE waits for real pin values and an idle cs_n, so a frame cut by
  // reset is never evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      shift       <= '0;
      bit_cnt     <= '0;
      settle      <= '0;
      state       <= ST_SETTLE;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
      if (!settled) settle <= settle + 2'd1;

      if (cs_fall) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (sclk_rise && !cs_s) begin
        shift <= {shift[FRAME_W-2:0], copi_s};
        if (bit_cnt != CNT_W'(CNT_MAX)) bit_cnt <= bit_cnt + CNT_W'(1);
      end

      case (state)
        ST_SETTLE: if (settled && cs_s) state <= ST_IDLE;
        ST_IDLE:   if (cs_fall)         state <= ST_FRAME;
        ST_FRAME:  if (cs_rise)         state <= ST_IDLE;
        default:                        state <= ST_SETTLE;
      endcase

      if (wr.wr_valid && wr.wr_ready) wr.wr_valid <= 1'b0;
      if (accept) begin
        wr.wr_valid <= 1'b1;
        wr.wr_addr  <= shift[ADDR_MSB:ADDR_LSB];
        wr.wr_data  <= shift[DATA_MSB:DATA_LSB];
      end
    end
  end

`ifdef SPI_FRAME_RX_ERR_CNT_EN
  logic reject;

  always_comb begin
    reject = eval && (!len_ok || (is_write && (!addr_ok || wr.wr_valid)));
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_cnt <= '0;
    else if (reject && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed self-checking bench for spi_frame_rx; err_cnt expectations follow SPI_FRAME_RX_ERR_CNT_EN.
module tb_spi_frame_rx;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] err_cnt;

  spi_frame_rx_if wr ();

  spi_frame_rx #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .cs_n(cs_n),
    .wr(wr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_model = 0;
  int hs_cnt = 0;
  logic [6:0] hs_addr = '0;
  logic [7:0] hs_data = '0;

  always @(posedge clk) begin
    if (!rst && wr.wr_valid && wr.wr_ready) begin
      hs_cnt  = hs_cnt + 1;
      hs_addr = wr.wr_addr;
      hs_data = wr.wr_data;
    end
  end

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    int          exp_hs;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    int          exp_err_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_err();
`ifdef SPI_FRAME_RX_ERR_CNT_EN
    return (err_model > 255) ? 8'd255 : 8'(err_model);
`else
    return 8'd0;
`endif
  endfunction

  task automatic cs_low();
    @(negedge clk) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [31:0] frame, input int msb, input int count);
    for (int i = msb; i > msb - count; i--) begin
      copi = frame[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] frame, input int nbits);
    cs_low();
    clock_bits(frame, nbits - 1, nbits);
    cs_high();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    err_model = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int hs0;
    wr.wr_ready = 1'b1;

    vecs[0] = '{32'h8255, 16, 1, 7'd2, 8'h55, 0};
    vecs[1] = '{32'h412A, 15, 0, 7'd0, 8'h00, 1};
    vecs[2] = '{32'h10AAB, 17, 0, 7'd0, 8'h00, 1};
    vecs[3] = '{32'h85AA, 16, 0, 7'd0, 8'h00, 1};
    vecs[4] = '{32'h02FF, 16, 0, 7'd0, 8'h00, 0};
    vecs[5] = '{32'h8433, 16, 1, 7'd4, 8'h33, 0};
    vecs[6] = '{32'h8000, 16, 1, 7'd0, 8'h00, 0};
    vecs[7] = '{32'hFF00, 16, 0, 7'd0, 8'h00, 1};

    repeat (4) @(negedge clk);
    check("rst_wr_valid", 32'(wr.wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr.wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr.wr_data), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      hs0 = hs_cnt;
      send_frame(vecs[v].frame, vecs[v].nbits);
      repeat (12) @(negedge clk);
      err_model += vecs[v].exp_err_inc;
      check($sformatf("vec%0d_handshakes", v), 32'(hs_cnt - hs0), 32'(vecs[v].exp_hs));
      if (vecs[v].exp_hs != 0) begin
        check($sformatf("vec%0d_addr", v), 32'(hs_addr), 32'(vecs[v].exp_addr));
        check($sformatf("vec%0d_data", v), 32'(hs_data), 32'(vecs[v].exp_data));
      end
      check($sformatf("vec%0d_valid_idle", v), 32'(wr.wr_valid), 32'd0);
      check($sformatf("vec%0d_err_cnt", v), 32'(err_cnt), 32'(exp_err()));
    end

    // Backpressure: pending write held, second frame is an overrun.
    do_reset();
    @(negedge clk) wr.wr_ready = 1'b0;
    hs0 = hs_cnt;
    send_frame(32'h8011, 16);
    @(posedge clk); @(posedge clk); #1;
    check("latency_not_early", 32'(wr.wr_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_valid", 32'(wr.wr_valid), 32'd1);
    send_frame(32'h8122, 16);
    repeat (12) @(negedge clk);
    err_model += 1;
    check("ovr_valid_held", 32'(wr.wr_valid), 32'd1);
    check("ovr_addr_held", 32'(wr.wr_addr), 32'd0);
    check("ovr_data_held", 32'(wr.wr_data), 32'h11);
    check("ovr_err_cnt", 32'(err_cnt), 32'(exp_err()));
    check("ovr_no_hs_yet", 32'(hs_cnt - hs0), 32'd0);
    @(negedge clk) wr.wr_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_valid_drop", 32'(wr.wr_valid), 32'd0);
    repeat (6) @(negedge clk);
    check("ovr_single_hs", 32'(hs_cnt - hs0), 32'd1);
    check("ovr_hs_data", 32'(hs_data), 32'h11);

    // Reset in the middle of a frame discards it.
    do_reset();
    hs0 = hs_cnt;
    cs_low();
    clock_bits(32'h8344, 15, 8);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    err_model = 0;
    clock_bits(32'h8344, 7, 8);
    cs_high();
    repeat (12) @(negedge clk);
    check("midrst_no_hs", 32'(hs_cnt - hs0), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'(exp_err()));
    send_frame(32'h8344, 16);
    repeat (12) @(negedge clk);
    check("midrst_recover_hs", 32'(hs_cnt - hs0), 32'd1);
    check("midrst_recover_addr", 32'(hs_addr), 32'd3);
    check("midrst_recover_data", 32'(hs_data), 32'h44);

    // 300 empty frames: saturation, no wrap.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      cs_low();
      cs_high();
      repeat (4) @(negedge clk);
      err_model += 1;
      if (n == 254) check("sat_at_255", 32'(err_cnt), 32'(exp_err()));
    end
    repeat (6) @(negedge clk);
    check("sat_final", 32'(err_cnt), 32'(exp_err()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per asynchronous SPI pin (legal 2..3).
REQ-002 SHALL have parameter NUM_REGS, default 5, meaning count of writable register addresses (0..NUM_REGS-1) in the downstream register bank.
REQ-003 SHALL have port clk  input  1  system clock; sole clock of the block.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port copi  input  1  SPI controller-out data, asynchronous to clk.
REQ-007 SHALL have port cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port wr_valid  output  1  a decoded write is pending.
REQ-009 SHALL have port wr_ready  input  1  downstream register bank accepts the pending write.
REQ-010 SHALL have port wr_addr  output  7  register address of the pending write.
REQ-011 SHALL have port wr_data  output  8  data byte of the pending write.
REQ-012 SHALL have port err_cnt  output  8  saturating count of rejected frames.

Function
REQ-013 SHALL synchronize sclk, copi and cs_n each through SYNC_STAGES flops before any use; all edge detection on synchronized copies.
REQ-014 SHALL use SPI mode 0: copi sampled on synchronized sclk rising edge while synchronized cs_n is low; falling edges ignored.
REQ-015 SHALL shift bits MSB first into a 16-bit shift register; frame layout bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-016 SHALL clear the shift register and the 5-bit bit counter on the synchronized cs_n falling edge.
REQ-017 SHALL saturate the bit counter at 17; counts above 16 mark the frame over-length.
REQ-018 SHALL evaluate the frame on the synchronized cs_n rising edge; frame accepted only when bit count = 16, R/W = 1, address < NUM_REGS.
REQ-019 SHALL treat read frames (R/W = 0) of exactly 16 bits as silently ignored: no write, no error count.
REQ-020 SHALL count as error: bit count != 16, or write with address >= NUM_REGS, or accepted frame arriving while wr_valid is high (overrun).
REQ-021 SHALL, on acceptance with wr_valid low, load wr_addr/wr_data and assert wr_valid on the cycle after the cs_n rising edge is detected: latency SYNC_STAGES+1 clk cycles from first clk edge sampling raw cs_n high.
REQ-022 SHALL hold wr_valid, wr_addr, wr_data stable until a clk edge with wr_valid and wr_ready both high, then deassert wr_valid the following cycle.
REQ-023 SHALL, on overrun, keep the pending write unchanged and drop the new frame; acceptance in the same cycle as a handshake completion counts as overrun, not as a new write.
REQ-024 SHALL ignore a synchronized sclk rising edge coinciding with the cs_n rising edge.
REQ-025 SHALL saturate err_cnt at 255; never wrap.

Reset
REQ-026 SHALL, while rst is high, drive wr_valid = 0, wr_addr = 0, wr_data = 0, err_cnt = 0, and clear shift register, bit counter and synchronizers (cs_n stages to 1, others to 0).
REQ-027 SHALL discard any partial frame on rst; a frame whose cs_n falling edge preceded rst release is neither accepted nor counted as error.

Configuration
REQ-028 SHALL compile the error counter only when macro SPI_FRAME_RX_ERR_CNT_EN is defined; without it err_cnt is tied to 0 and no counter flops exist, frame rejection behaviour unchanged.

Structure
REQ-029 SHALL take frame width (16), field positions, R/W encoding and NUM_REGS default from shared package spi_rx_pkg.
REQ-030 SHALL implement synchronization in sub-module spi_sync (parameterized depth, reset value), instantiated once per SPI pin.

Verification
REQ-031 SHALL cover: write frame 0x8255 (addr 2, data 0x55), wr_ready = 1 -> one wr_valid pulse, wr_addr = 2, wr_data = 0x55, err_cnt = 0.
REQ-032 SHALL cover: 15-bit frame then 17-bit frame -> no wr_valid, err_cnt = 2.
REQ-033 SHALL cover: write to addr 5 (0x85AA) -> no wr_valid, err_cnt = 1; read frame 0x02FF -> no wr_valid, err_cnt unchanged.
REQ-034 SHALL cover: wr_ready = 0, frames 0x8011 then 0x8122 -> wr_valid held with addr 0/data 0x11, err_cnt = 1; wr_ready = 1 -> single handshake, then wr_valid = 0.
REQ-035 SHALL cover: rst pulsed after 8 bits of 0x8344 then remaining bits and cs_n high -> no wr_valid, err_cnt = 0.
REQ-036 SHALL cover: build without SPI_FRAME_RX_ERR_CNT_EN, 300 bad frames -> err_cnt = 0; with macro, same stimulus -> err_cnt = 255.
